// File: rtl/dpu_layer_sequencer.sv
// Fully-connected layer sequencer: walks the output neurons one tile of NUM_UNITS
// lanes at a time through operand fetch, one DPU pass and result writeback.
module dpu_layer_sequencer #(
  parameter int NUM_UNITS = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [15:0]          cmd_num_outputs,
  output logic                 fetch_req,
  output logic [15:0]          fetch_tile,
  input  logic                 fetch_ack,
  output logic                 dpu_start,
  output logic [NUM_UNITS-1:0] dpu_active_units,
  input  logic                 dpu_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [15:0]          res_tile,
  output logic [NUM_UNITS-1:0] res_mask,
  output logic                 busy,
  output logic                 layer_done,
  output logic                 err_timeout,
  output logic [2:0]           dbg_state
);
  // Handshakes: a transfer happens on the rising edge where both sides are high
  // (cmd_valid/cmd_ready, fetch_req/fetch_ack, res_valid/res_ready); the
  // requesting side holds its request and payload stable until that edge.
  localparam int LANE_W = $clog2(NUM_UNITS);
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ABORT = CNT_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_WRITE  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [15:0]            r_tile;
  logic [15:0]            r_last_tile;
  logic [NUM_UNITS-1:0]   r_last_mask;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_tile_inc;
  logic                   w_abort;
  logic                   w_lanes_on;
  logic [15:0]            w_last_tile;
  logic [LANE_W-1:0]      w_rem;
  logic [NUM_UNITS-1:0]   w_last_mask;

  // Last tile index is (N-1)/NUM_UNITS; only meaningful for N > 0.
  assign w_last_tile = (cmd_num_outputs - 16'd1) >> LANE_W;
  assign w_rem       = cmd_num_outputs[LANE_W-1:0];

  always_comb begin
    w_last_mask = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_last_mask[i] = (w_rem == '0) || (i < int'(w_rem));
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_tile_inc   = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = (cmd_num_outputs == 16'd0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: if (fetch_ack) w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT: begin
        // done has priority over an abort in the same cycle
        if (dpu_done) begin
          w_state_next = S_WRITE;
        end else if (r_cnt == CNT_ABORT) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WRITE: begin
        if (res_ready) begin
          if (r_tile == r_last_tile) begin
            w_state_next = S_FINISH;
          end else begin
            w_tile_inc   = 1'b1;
            w_state_next = S_FETCH;
          end
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_lanes_on       = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_WRITE);
  assign cmd_ready        = (r_state == S_IDLE);
  assign fetch_req        = (r_state == S_FETCH);
  assign fetch_tile       = fetch_req ? r_tile : 16'd0;
  assign dpu_start        = (r_state == S_START);
  assign dpu_active_units = !w_lanes_on ? '0 : ((r_tile == r_last_tile) ? r_last_mask : '1);
  assign res_valid        = (r_state == S_WRITE);
  assign res_tile         = res_valid ? r_tile : 16'd0;
  assign res_mask         = dpu_active_units;
  assign busy             = (r_state != S_IDLE);
  assign layer_done       = (r_state == S_FINISH);
  assign err_timeout      = r_err;
  assign dbg_state        = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tile      <= 16'd0;
      r_last_tile <= 16'd0;
      r_last_mask <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_tile      <= 16'd0;
        r_last_tile <= w_last_tile;
        r_last_mask <= w_last_mask;
        r_err       <= 1'b0;
      end else if (w_tile_inc && (r_tile != r_last_tile)) begin
        r_tile <= r_tile + 16'd1;
      end
      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_cnt != CNT_LAST)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dpu_layer_sequencer.sv
// Directed bench for dpu_layer_sequencer (NUM_UNITS=16, TIMEOUT=8) with
// hand-computed tile/mask/latency expectations.
module tb_dpu_layer_sequencer;
  localparam int NU = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [15:0]   cmd_num_outputs = 16'd0;
  logic          fetch_req;
  logic [15:0]   fetch_tile;
  logic          fetch_ack = 1'b0;
  logic          dpu_start;
  logic [NU-1:0] dpu_active_units;
  logic          dpu_done = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_tile;
  logic [NU-1:0] res_mask;
  logic          busy;
  logic          layer_done;
  logic          err_timeout;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] m_fetch_q[$];
  logic [15:0] m_mask_q[$];
  logic [15:0] m_res_tile_q[$];
  logic [15:0] m_res_mask_q[$];
  int m_starts, m_dones, m_done_cyc, m_start_cyc, m_err_cyc;
  int m_fetch_hi, m_res_hi, m_unstable, m_ready_busy;
  bit m_ended;

  dpu_layer_sequencer #(.NUM_UNITS(NU), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_outputs(cmd_num_outputs),
    .fetch_req(fetch_req), .fetch_tile(fetch_tile), .fetch_ack(fetch_ack),
    .dpu_start(dpu_start), .dpu_active_units(dpu_active_units), .dpu_done(dpu_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_tile(res_tile), .res_mask(res_mask),
    .busy(busy), .layer_done(layer_done), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver + monitor: issues one command, answers fetch/done/res handshakes
  // after the given delays, and records what the DUT emitted per cycle.
  task automatic run_cmd(input logic [15:0] n, input int ack_dly, input int rdy_dly,
                         input bit give_done, input int max_cyc);
    int fcnt, rcnt, tail;
    bit prev_start, prev_freq, prev_rval;
    logic [15:0] prev_ftile, prev_rtile, prev_rmask;
    fcnt = 0; rcnt = 0; tail = 0;
    prev_start = 0; prev_freq = 0; prev_rval = 0;
    prev_ftile = 0; prev_rtile = 0; prev_rmask = 0;
    m_fetch_q.delete(); m_mask_q.delete(); m_res_tile_q.delete(); m_res_mask_q.delete();
    m_starts = 0; m_dones = 0; m_done_cyc = -1; m_start_cyc = -1; m_err_cyc = -1;
    m_fetch_hi = 0; m_res_hi = 0; m_unstable = 0; m_ready_busy = 0; m_ended = 0;
    @(negedge clk);
    cmd_num_outputs = n;
    cmd_valid = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (cmd_ready && busy) m_ready_busy++;
      if (fetch_req) begin
        m_fetch_hi++;
        if (!prev_freq) m_fetch_q.push_back(fetch_tile);
        else if (fetch_tile !== prev_ftile) m_unstable++;
        fetch_ack = (fcnt >= ack_dly);
        fcnt++;
      end else begin
        fetch_ack = 1'b0;
        fcnt = 0;
      end
      prev_freq = fetch_req; prev_ftile = fetch_tile;
      if (dpu_start) begin
        m_starts++;
        m_mask_q.push_back(dpu_active_units);
        m_start_cyc = c;
      end
      dpu_done = give_done && prev_start;
      prev_start = dpu_start;
      if (res_valid) begin
        m_res_hi++;
        if (!prev_rval) begin
          m_res_tile_q.push_back(res_tile);
          m_res_mask_q.push_back(res_mask);
        end else if (res_tile !== prev_rtile || res_mask !== prev_rmask) m_unstable++;
        res_ready = (rcnt >= rdy_dly);
        rcnt++;
      end else begin
        res_ready = 1'b0;
        rcnt = 0;
      end
      prev_rval = res_valid; prev_rtile = res_tile; prev_rmask = res_mask;
      if (layer_done) begin
        m_dones++;
        m_done_cyc = c;
      end
      if (err_timeout && m_err_cyc < 0) m_err_cyc = c;
      if (layer_done || err_timeout) m_ended = 1;
      if (m_ended) begin
        tail++;
        if (tail > 3) break;
      end
    end
    fetch_ack = 1'b0; dpu_done = 1'b0; res_ready = 1'b0;
    if (!m_ended) begin
      n_cmp++; n_err++;
      $display("FAIL run_bound: command N=%0d did not end within %0d cycles", n, max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if ({fetch_req, dpu_start, res_valid, busy, layer_done, err_timeout} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000000", {fetch_req, dpu_start, res_valid, busy, layer_done, err_timeout}); end
    n_cmp++; if ({fetch_tile, res_tile, dpu_active_units, res_mask} !== 64'h0) begin
      n_err++; $display("FAIL reset_buses: got %h expected 0", {fetch_tile, res_tile, dpu_active_units, res_mask}); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_tile();
    run_cmd(16'd16, 0, 0, 1'b1, 40);
    n_cmp++; if (m_fetch_q.size() != 1 || m_fetch_q[0] !== 16'd0) begin
      n_err++; $display("FAIL single_fetch: got %0d reqs first tile %0d expected 1 req tile 0", m_fetch_q.size(), m_fetch_q[0]); end
    n_cmp++; if (m_starts != 1 || m_mask_q[0] !== 16'hFFFF) begin
      n_err++; $display("FAIL single_start: got %0d starts mask %h expected 1 start mask ffff", m_starts, m_mask_q[0]); end
    n_cmp++; if (m_res_tile_q.size() != 1 || m_res_tile_q[0] !== 16'd0 || m_res_mask_q[0] !== 16'hFFFF) begin
      n_err++; $display("FAIL single_res: got %0d results tile %0d mask %h expected 1 tile 0 mask ffff",
                        m_res_tile_q.size(), m_res_tile_q[0], m_res_mask_q[0]); end
    n_cmp++; if (m_dones != 1 || m_done_cyc != 5) begin
      n_err++; $display("FAIL single_latency: got %0d dones at cycle %0d expected 1 at cycle 5", m_dones, m_done_cyc); end
    n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL single_idle: got busy %b ready %b expected 0 1", busy, cmd_ready); end
  endtask

  task automatic test_multi_tile();
    run_cmd(16'd37, 0, 0, 1'b1, 60);
    exp_q = '{16'd0, 16'd1, 16'd2};
    n_cmp++; if (m_fetch_q.size() != 3 || m_res_tile_q.size() != 3) begin
      n_err++; $display("FAIL multi_counts: got %0d fetches %0d results expected 3 3", m_fetch_q.size(), m_res_tile_q.size()); end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= m_fetch_q.size() || m_fetch_q[i] !== exp_q[i] || i >= m_res_tile_q.size() || m_res_tile_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL multi_tile_%0d: got fetch %0d res %0d expected %0d", i, m_fetch_q[i], m_res_tile_q[i], exp_q[i]); end
    end
    exp_q = '{16'hFFFF, 16'hFFFF, 16'h001F};
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= m_mask_q.size() || m_mask_q[i] !== exp_q[i] || i >= m_res_mask_q.size() || m_res_mask_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL multi_mask_%0d: got start %h res %h expected %h", i, m_mask_q[i], m_res_mask_q[i], exp_q[i]); end
    end
    n_cmp++; if (m_starts != 3 || m_dones != 1 || m_done_cyc != 13) begin
      n_err++; $display("FAIL multi_pulses: got starts %0d dones %0d at %0d expected 3 1 at 13", m_starts, m_dones, m_done_cyc); end
    n_cmp++; if (m_ready_busy != 0) begin
      n_err++; $display("FAIL multi_ready_busy: got %0d overlapping cycles expected 0", m_ready_busy); end
  endtask

  task automatic test_zero();
    run_cmd(16'd0, 0, 0, 1'b1, 20);
    n_cmp++; if (m_dones != 1 || m_done_cyc != 1) begin
      n_err++; $display("FAIL zero_latency: got %0d dones at cycle %0d expected 1 at cycle 1", m_dones, m_done_cyc); end
    n_cmp++; if (m_fetch_hi != 0 || m_starts != 0 || m_res_hi != 0) begin
      n_err++; $display("FAIL zero_quiet: got fetch %0d start %0d res %0d expected 0 0 0", m_fetch_hi, m_starts, m_res_hi); end
  endtask

  task automatic test_backpressure();
    run_cmd(16'd20, 3, 5, 1'b1, 80);
    n_cmp++; if (m_fetch_hi != 8 || m_res_hi != 12) begin
      n_err++; $display("FAIL bp_hold: got fetch_req %0d res_valid %0d cycles expected 8 12", m_fetch_hi, m_res_hi); end
    n_cmp++; if (m_unstable != 0) begin
      n_err++; $display("FAIL bp_stable: got %0d payload changes expected 0", m_unstable); end
    n_cmp++; if (m_mask_q.size() != 2 || m_mask_q[0] !== 16'hFFFF || m_mask_q[1] !== 16'h000F) begin
      n_err++; $display("FAIL bp_masks: got %0d masks %h %h expected ffff 000f", m_mask_q.size(), m_mask_q[0], m_mask_q[1]); end
    n_cmp++; if (m_res_mask_q.size() != 2 || m_res_mask_q[1] !== 16'h000F || m_res_tile_q[1] !== 16'd1) begin
      n_err++; $display("FAIL bp_res: got tile %0d mask %h expected 1 000f", m_res_tile_q[1], m_res_mask_q[1]); end
    n_cmp++; if (m_dones != 1 || m_done_cyc != 25) begin
      n_err++; $display("FAIL bp_latency: got %0d dones at %0d expected 1 at 25", m_dones, m_done_cyc); end
  endtask

  task automatic test_timeout();
    run_cmd(16'd16, 0, 0, 1'b0, 40);
    n_cmp++; if (m_starts != 1 || m_err_cyc - m_start_cyc != 8) begin
      n_err++; $display("FAIL to_delay: got err %0d cycles after start (starts %0d) expected 8", m_err_cyc - m_start_cyc, m_starts); end
    n_cmp++; if (m_dones != 0 || m_res_hi != 0) begin
      n_err++; $display("FAIL to_no_done: got dones %0d res %0d expected 0 0", m_dones, m_res_hi); end
    n_cmp++; if (err_timeout !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0 || dpu_active_units !== 16'h0) begin
      n_err++; $display("FAIL to_idle: got err %b ready %b busy %b mask %h expected 1 1 0 0000",
                        err_timeout, cmd_ready, busy, dpu_active_units); end
    run_cmd(16'd16, 0, 0, 1'b1, 40);
    n_cmp++; if (m_err_cyc != -1 || m_dones != 1 || m_done_cyc != 5) begin
      n_err++; $display("FAIL to_recover: got err cycle %0d dones %0d at %0d expected -1 1 at 5", m_err_cyc, m_dones, m_done_cyc); end
  endtask

  task automatic test_reset_mid();
    int starts, bad;
    bit reached;
    starts = 0; bad = 0; reached = 0;
    @(negedge clk);
    cmd_num_outputs = 16'd48;
    cmd_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      fetch_ack = fetch_req;
      res_ready = res_valid;
      dpu_done = (dbg_state == 3'd3) && (starts < 2);
      if (dbg_state == 3'd3 && starts == 2) begin
        reached = 1;
        break;
      end
      if (dpu_start) starts++;
    end
    n_cmp++; if (!reached) begin n_err++; $display("FAIL rm_reach: got starts %0d expected WAIT of tile 1", starts); end
    fetch_ack = 1'b0; res_ready = 1'b0; dpu_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1 || {fetch_req, dpu_start, res_valid, busy, layer_done, err_timeout} !== 6'b0) begin
      n_err++; $display("FAIL rm_async_flags: got ready %b flags %b expected 1 000000", cmd_ready,
                        {fetch_req, dpu_start, res_valid, busy, layer_done, err_timeout}); end
    n_cmp++; if ({fetch_tile, res_tile, dpu_active_units, res_mask} !== 64'h0 || dbg_state !== 3'd0) begin
      n_err++; $display("FAIL rm_async_buses: got %h state %0d expected 0 0",
                        {fetch_tile, res_tile, dpu_active_units, res_mask}, dbg_state); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    dpu_done = 1'b1;
    @(negedge clk);
    dpu_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (res_valid || busy || layer_done || dpu_start || fetch_req) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rm_quiet: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dpu_layer_sequencer.md
Name: dpu_layer_sequencer

Overview:
- Sequences one fully-connected layer (y = relu(W·x + b)) over the shared dot_product_multiplication_unit (DPU), one tile of NUM_UNITS outputs at a time.
- Per tile:
  - requests operand/bias load from the buffer manager;
  - pulses the DPU start and waits for the DPU done;
  - hands the relu_out tile to the writeback path.
- Sits between the layer command queue and the DPU, its operand buffers and the result buffer.

Parameters:
- NUM_UNITS, 16, DPU lanes per tile; power of two, 2..64.
- TIMEOUT, 1024, max cycles in WAIT for dpu_done before abort; ≥ 4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  layer command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_num_outputs  in  16  output neurons in layer; 0 legal.
- fetch_req  out  1  request operand/bias load for fetch_tile.
- fetch_tile  out  16  tile index being fetched.
- fetch_ack  in  1  operands for fetch_tile now stable on DPU inputs.
- dpu_start  out  1  one-cycle DPU start pulse.
- dpu_active_units  out  NUM_UNITS  lane mask to the DPU.
- dpu_done  in  1  DPU result valid.
- res_valid  out  1  relu_out tile ready for writeback.
- res_ready  in  1  writeback accepts tile.
- res_tile  out  16  tile index of result.
- res_mask  out  NUM_UNITS  valid lanes of result (= dpu_active_units).
- busy  out  1  command in progress.
- layer_done  out  1  one-cycle pulse, layer complete.
- err_timeout  out  1  sticky abort flag.

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE;
  - all outputs 0 except cmd_ready = 1;
  - tile counter 0, timeout counter 0, err_timeout 0.
- Reset mid-layer aborts immediately with no further pulses.
- Tile count: T = ceil(N / NUM_UNITS), where N = cmd_num_outputs, latched on accept.
- Lane mask:
  - full mask for tiles 0..T-2;
  - last tile mask = low (N mod NUM_UNITS) bits set, or all ones if the remainder is 0.
- FSM states: IDLE, FETCH, START, WAIT, WRITE, FINISH.
- IDLE:
  - cmd_ready = 1.
  - Accept occurs on cmd_valid & cmd_ready: latch N, clear tile counter, clear err_timeout, assert busy from the next cycle.
  - If N = 0, go to FINISH; else go to FETCH.
- FETCH:
  - fetch_req = 1 with stable fetch_tile until the cycle fetch_ack = 1, then go to START.
  - fetch_ack outside FETCH is ignored.
- START:
  - dpu_start = 1 for exactly one cycle; dpu_active_units valid here and held through WRITE.
  - Clear the timeout counter; go to WAIT.
  - dpu_done in START is ignored.
- WAIT:
  - The counter increments each cycle.
  - dpu_done = 1 goes to WRITE.
  - Counter reaching TIMEOUT-1 without done: set err_timeout, drop busy and the mask, go to IDLE with no layer_done.
  - dpu_done and timeout in the same cycle: done wins.
- WRITE:
  - res_valid = 1 with stable res_tile/res_mask until res_ready.
  - On handshake: if tile = T-1 go to FINISH; else increment tile and go to FETCH (next fetch_req the following cycle).
- FINISH: layer_done = 1 for one cycle, busy = 0 next cycle, go to IDLE.
- Minimum per-tile latency, with ack, done and ready all immediate: 4 cycles (FETCH, START, WAIT, WRITE).
- Minimum N = 0 latency: accept → layer_done 1 cycle later.
- cmd_valid while busy is not accepted (cmd_ready = 0).
- dpu_active_units = 0 whenever not in START/WAIT/WRITE.
- Counters saturate; tile never exceeds T-1.

Test Plan:
- Reset then N = 16 (NUM_UNITS = 16), ack/done/ready immediate:
  - one fetch_req with tile 0;
  - one dpu_start with mask 16'hFFFF;
  - res_valid tile 0, then layer_done;
  - accept → done = 5 cycles.
- N = 37:
  - tiles 0, 1, 2 with masks FFFF, FFFF, 001F;
  - exactly 3 dpu_start pulses, one layer_done.
- N = 0: layer_done one cycle after accept; no fetch_req, dpu_start or res_valid.
- Backpressure on N = 20:
  - fetch_ack delayed 3 cycles and res_ready held low 5 cycles;
  - fetch_req/res_valid stay high with stable index/mask throughout;
  - second tile mask 000F.
- dpu_done never asserted with TIMEOUT = 8:
  - err_timeout = 1 eight cycles after dpu_start, no layer_done, cmd_ready = 1;
  - a new N = 16 command clears err_timeout and completes.
- Reset asserted during WAIT of tile 1 of N = 48:
  - all outputs 0 and cmd_ready = 1 asynchronously;
  - a later dpu_done pulse causes no res_valid.
